// File: rtl/picorv_mem_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port between the CPU (m0) and a DMA loader (m1).
// Define ARB_TIMEOUT_EN to self-complete slave accesses stalled for TIMEOUT_CYCLES with 0xDEADBEEF.
`timescale 1ns/1ps
module picorv_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("picorv_mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                w_own0;
  logic                w_own1;
  logic                w_own_valid;
  logic                w_done;
  logic                w_tmo_fire;
  logic [DATA_W-1:0]   w_rdata;

  assign w_own0      = (r_state == OWN0);
  assign w_own1      = (r_state == OWN1);
  assign w_own_valid = (w_own0 & m0_valid) | (w_own1 & m1_valid);

`ifdef ARB_TIMEOUT_EN
  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TMO_RDATA = DATA_W'(32'hDEAD_BEEF);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // The arbiter answers in place of a slave that has stalled too long.
  assign w_tmo_fire = w_own_valid & ~s_ready & (r_tmo_cnt == TMO_LAST);
  assign w_rdata    = w_tmo_fire ? TMO_RDATA : s_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if ((r_state == IDLE) || w_tmo_fire)
        r_tmo_cnt <= '0;
      else if (s_valid && !s_ready)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo_fire)
        r_tmo_err <= 1'b1;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  assign w_tmo_fire  = 1'b0;
  assign w_rdata     = s_rdata;
  assign timeout_err = 1'b0;
`endif

  assign s_valid = w_own_valid & ~w_tmo_fire;
  assign w_done  = (s_valid & s_ready) | w_tmo_fire;

  always_comb begin
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = {STRB_W{1'b0}};
    case (r_state)
      OWN0: begin
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
      OWN1: begin
        s_instr = m1_instr;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end
      default: ;
    endcase
  end

  assign m0_ready = w_own0 & w_done;
  assign m1_ready = w_own1 & w_done;
  assign m0_rdata = w_own0 ? w_rdata : '0;
  assign m1_rdata = w_own1 ? w_rdata : '0;
  assign grant    = {w_own1, w_own0};

  // r_last holds the most recent master that completed; ties go to the other one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_valid && (!m1_valid || r_last))
            r_state <= OWN0;
          else if (m1_valid)
            r_state <= OWN1;
        end
        OWN0: begin
          if (w_done) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
          end else if (!m0_valid) begin
            r_state <= IDLE;
          end
        end
        OWN1: begin
          if (w_done) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
          end else if (!m1_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Scoreboard testbench for picorv_mem_arbiter with a latency-configurable slave model.
`timescale 1ns/1ps
module tb_picorv_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m0_instr = 1'b0, m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  picorv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } cpl_t;

  req_t       rq0[$], rq1[$];
  cpl_t       exp_q[$], got_q[$];
  logic [2:0] trace[$];
  int         n_cmp = 0, n_err = 0, viol = 0;
  int         sl_lat = 0, sw_cnt = 0;
  bit         sl_stall = 1'b0, rand_lat = 1'b0;

  // Slave model: answers once s_valid has been held for sl_lat cycles, unless stalled.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h100) return 32'h1234_5678;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  always @(posedge clk) begin
    if (!s_valid || s_ready) sw_cnt <= 0;
    else sw_cnt <= sw_cnt + 1;
  end
  assign s_ready = s_valid && !sl_stall && (sw_cnt >= sl_lat);
  assign s_rdata = slave_data(s_addr);

  function automatic cpl_t mk_cpl(input logic id, input req_t r);
    cpl_t c;
    c.id = id; c.rdata = slave_data(r.addr); c.addr = r.addr;
    c.wdata = r.wdata; c.wstrb = r.wstrb; c.instr = r.instr;
    return c;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.addr = $urandom & 32'hFFFF_FFFC; r.wdata = $urandom;
    r.wstrb = 4'($urandom_range(0, 15)); r.instr = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [63:0] trace_vec();
    logic [63:0] v = 64'd1;
    foreach (trace[i]) v = {v[60:0], trace[i]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_masters();
    tick();
    if (rand_lat) sl_lat = $urandom_range(0, 3);
    m0_valid = (rq0.size() != 0);
    if (m0_valid) {m0_addr, m0_wdata, m0_wstrb, m0_instr} = rq0[0];
    m1_valid = (rq1.size() != 0);
    if (m1_valid) {m1_addr, m1_wdata, m1_wstrb, m1_instr} = rq1[0];
  endtask

  task automatic sample();
    cpl_t c;
    @(negedge clk);
    trace.push_back({s_valid, grant});
    if (m0_ready) begin
      c = {1'b0, m0_rdata, s_addr, s_wdata, s_wstrb, s_instr};
      got_q.push_back(c);
      if (rq0.size() != 0) void'(rq0.pop_front());
    end
    if (m1_ready) begin
      c = {1'b1, m1_rdata, s_addr, s_wdata, s_wstrb, s_instr};
      got_q.push_back(c);
      if (rq1.size() != 0) void'(rq1.pop_front());
    end
    if ((m0_ready && grant != 2'b01) || (m1_ready && grant != 2'b10)) viol++;
    if ((grant != 2'b01 && m0_rdata != 0) || (grant != 2'b10 && m1_rdata != 0)) viol++;
  endtask

  task automatic run_queues(input int budget, output bit timed_out);
    int n = 0;
    while ((rq0.size() != 0 || rq1.size() != 0) && n < budget) begin
      drive_masters(); sample(); n++;
    end
    drive_masters(); sample();
    timed_out = (n >= budget);
  endtask

  task automatic do_reset();
    tick();
    resetn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    sl_stall = 1'b0; sl_lat = 0; rand_lat = 1'b0;
    rq0.delete(); rq1.delete(); exp_q.delete(); got_q.delete(); trace.delete();
    tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    resetn = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'hFFFF_FFF0; m0_wdata = 32'hFFFF_FFFF; m0_wstrb = 4'hF; m0_instr = 1'b1;
    m1_valid = 1'b1; m1_addr = 32'hAAAA_0000; m1_wdata = 32'h5555_5555; m1_wstrb = 4'hF;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b, required 00", grant); end
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_s_valid: got %b, required 0", s_valid); end
    n_cmp++;
    if ({s_instr, s_addr, s_wdata, s_wstrb} !== '0) begin
      n_err++; $display("FAIL reset_s_fields: got instr=%b addr=%h wdata=%h wstrb=%h, required all 0", s_instr, s_addr, s_wdata, s_wstrb);
    end
    n_cmp++; if ({m0_ready, m1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b, required 00", {m0_ready, m1_ready}); end
    n_cmp++;
    if ({m0_rdata, m1_rdata} !== 64'd0) begin
      n_err++; $display("FAIL reset_rdata: got %h/%h, required 0/0", m0_rdata, m1_rdata);
    end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b, required 0", timeout_err); end
    m0_valid = 1'b0; m1_valid = 1'b0; m0_instr = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    cpl_t e, g; bit to;
    do_reset();
    sl_lat = 2;
    rq0.push_back({32'h100, 32'h0, 4'h0, 1'b0});
    exp_q.push_back(mk_cpl(1'b0, rq0[0]));
    run_queues(40, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL single_read_budget: timed out, required completion"); end
    n_cmp++;
    if (trace_vec() !== 64'({1'b1, 3'b000, 3'b101, 3'b101, 3'b101, 3'b000})) begin
      n_err++; $display("FAIL single_read_trace: got %h, required %h", trace_vec(), 64'({1'b1, 3'b000, 3'b101, 3'b101, 3'b101, 3'b000}));
    end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL single_read_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL single_read_cpl: got id=%0d rdata=%h addr=%h, required id=%0d rdata=%h addr=%h", g.id, g.rdata, g.addr, e.id, e.rdata, e.addr); end
    end
  endtask

  task automatic test_round_robin();
    cpl_t e, g; bit to;
    do_reset();
    rq0.push_back({32'h40, 32'h0, 4'h0, 1'b1});
    rq0.push_back({32'h44, 32'h0, 4'h0, 1'b1});
    rq1.push_back({32'h2000_0000, 32'hCAFE_0001, 4'hF, 1'b0});
    exp_q.push_back(mk_cpl(1'b0, rq0[0]));
    exp_q.push_back(mk_cpl(1'b1, rq1[0]));
    exp_q.push_back(mk_cpl(1'b0, rq0[1]));
    run_queues(40, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL round_robin_budget: timed out, required completion"); end
    n_cmp++;
    if (trace_vec() !== 64'({1'b1, 3'b000, 3'b101, 3'b000, 3'b110, 3'b000, 3'b101, 3'b000})) begin
      n_err++; $display("FAIL round_robin_trace: got %h, required %h", trace_vec(), 64'({1'b1, 3'b000, 3'b101, 3'b000, 3'b110, 3'b000, 3'b101, 3'b000}));
    end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL round_robin_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL round_robin_cpl: got id=%0d addr=%h instr=%b rdata=%h, required id=%0d addr=%h instr=%b rdata=%h", g.id, g.addr, g.instr, g.rdata, e.id, e.addr, e.instr, e.rdata); end
    end
  endtask

  task automatic test_m1_write();
    cpl_t e, g; bit to;
    do_reset();
    sl_lat = 1;
    rq1.push_back({32'h1000_0000, 32'h0000_0041, 4'b0001, 1'b0});
    exp_q.push_back(mk_cpl(1'b1, rq1[0]));
    run_queues(40, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL m1_write_budget: timed out, required completion"); end
    n_cmp++;
    if (trace_vec() !== 64'({1'b1, 3'b000, 3'b110, 3'b110, 3'b000})) begin
      n_err++; $display("FAIL m1_write_trace: got %h, required %h", trace_vec(), 64'({1'b1, 3'b000, 3'b110, 3'b110, 3'b000}));
    end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL m1_write_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL m1_write_cpl: got id=%0d addr=%h wdata=%h wstrb=%b, required id=%0d addr=%h wdata=%h wstrb=%b", g.id, g.addr, g.wdata, g.wstrb, e.id, e.addr, e.wdata, e.wstrb); end
    end
  endtask

  task automatic test_back_to_back();
    cpl_t e, g; bit to, last;
    req_t a0[$], a1[$];
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 4; i++) rq0.push_back(rnd_req());
    for (int i = 0; i < 6; i++) rq1.push_back(rnd_req());
    a0 = rq0; a1 = rq1; last = 1'b1;
    while (a0.size() != 0 || a1.size() != 0) begin
      if (a0.size() != 0 && (a1.size() == 0 || last)) begin exp_q.push_back(mk_cpl(1'b0, a0.pop_front())); last = 1'b0; end
      else begin exp_q.push_back(mk_cpl(1'b1, a1.pop_front())); last = 1'b1; end
    end
    run_queues(200, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL back_to_back_budget: timed out, required completion"); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL back_to_back_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL back_to_back_cpl: got id=%0d addr=%h wdata=%h wstrb=%b instr=%b rdata=%h, required id=%0d addr=%h wdata=%h wstrb=%b instr=%b rdata=%h", g.id, g.addr, g.wdata, g.wstrb, g.instr, g.rdata, e.id, e.addr, e.wdata, e.wstrb, e.instr, e.rdata); end
    end
  endtask

  task automatic test_reset_mid();
    cpl_t e, g; bit to;
    do_reset();
    sl_stall = 1'b1;
    tick(); m1_valid = 1'b1; m1_addr = 32'h3000; m1_wstrb = 4'h0;
    @(negedge clk);
    tick(); @(negedge clk);
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL reset_mid_own1: got grant %b, required 10", grant); end
    tick(); resetn = 1'b0; m0_valid = 1'b1; m0_addr = 32'h10;
    @(negedge clk);
    tick(); @(negedge clk);
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_s_valid: got %b, required 0", s_valid); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_mid_grant: got %b, required 00", grant); end
    n_cmp++; if ({m0_ready, m1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_mid_ready: got %b, required 00", {m0_ready, m1_ready}); end
    n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL reset_mid_no_cpl: got %0d completions, required 0", got_q.size()); end
    tick(); m0_valid = 1'b0; m1_valid = 1'b0; sl_stall = 1'b0; resetn = 1'b1;
    rq0.push_back({32'h10, 32'h0, 4'h0, 1'b1});
    rq1.push_back({32'h3000, 32'h77, 4'h3, 1'b0});
    exp_q.push_back(mk_cpl(1'b0, rq0[0]));
    exp_q.push_back(mk_cpl(1'b1, rq1[0]));
    run_queues(40, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL reset_mid_budget: timed out, required completion"); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL reset_mid_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset_mid_cpl: got id=%0d addr=%h, required id=%0d addr=%h", g.id, g.addr, e.id, e.addr); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    sl_stall = 1'b1;
    tick(); m0_valid = 1'b1; m0_addr = 32'h200; m0_wstrb = 4'h0; m0_instr = 1'b0;
    @(negedge clk);
    tick(); m1_valid = 1'b1; m1_addr = 32'h300; m1_wstrb = 4'h0;
    @(negedge clk);
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL abort_own0: got grant %b, required 01", grant); end
    tick(); m0_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({s_valid, m0_ready} !== 2'b00) begin n_err++; $display("FAIL abort_drop: got s_valid,m0_ready %b, required 00", {s_valid, m0_ready}); end
    tick(); @(negedge clk);
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL abort_idle: got grant %b, required 00", grant); end
    tick(); @(negedge clk);
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL abort_m1_grant: got grant %b, required 10", grant); end
    tick(); sl_stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m1_ready, m1_rdata} !== {1'b1, slave_data(32'h300)}) begin
      n_err++; $display("FAIL abort_m1_done: got ready=%b rdata=%h, required ready=1 rdata=%h", m1_ready, m1_rdata, slave_data(32'h300));
    end
    tick(); m1_valid = 1'b0; m0_valid = 1'b1; m0_addr = 32'h400;
    @(negedge clk);
    tick(); @(negedge clk);
    n_cmp++; if (m0_ready !== 1'b1) begin n_err++; $display("FAIL abort_m0_done: got m0_ready %b, required 1", m0_ready); end
    tick(); m0_valid = 1'b0; m1_valid = 1'b1; m1_addr = 32'h500; sl_stall = 1'b1;
    @(negedge clk);
    tick(); @(negedge clk);
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL abort_own1: got grant %b, required 10", grant); end
    tick(); m1_valid = 1'b0;
    @(negedge clk);
    tick(); m0_valid = 1'b1; m1_valid = 1'b1;
    @(negedge clk);
    tick(); @(negedge clk);
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL abort_ptr_kept: got grant %b after tie, required 10", grant); end
    tick(); m0_valid = 1'b0; m1_valid = 1'b0; sl_stall = 1'b0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    cpl_t e, g; bit to;
    do_reset();
    sl_stall = 1'b1;
    tick(); m0_valid = 1'b1; m0_addr = 32'h600; m0_wstrb = 4'h0; m0_instr = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (k < 4) begin
        if ({m0_ready, s_valid} !== 2'b01) begin n_err++; $display("FAIL timeout_wait_%0d: got ready,s_valid %b, required 01", k, {m0_ready, s_valid}); end
      end else begin
        if ({m0_ready, m0_rdata, s_valid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
          n_err++; $display("FAIL timeout_fire: got ready=%b rdata=%h s_valid=%b, required 1 deadbeef 0", m0_ready, m0_rdata, s_valid);
        end
      end
    end
    tick(); m0_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({grant, timeout_err} !== 3'b001) begin n_err++; $display("FAIL timeout_err_set: got grant=%b err=%b, required 00 1", grant, timeout_err); end
    sl_stall = 1'b0;
    rq0.push_back({32'h900, 32'h0, 4'h0, 1'b0});
    rq1.push_back({32'h904, 32'h1234, 4'hC, 1'b0});
    exp_q.push_back(mk_cpl(1'b1, rq1[0]));
    exp_q.push_back(mk_cpl(1'b0, rq0[0]));
    run_queues(40, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL timeout_after_budget: timed out, required completion"); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL timeout_after_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL timeout_after_cpl: got id=%0d addr=%h rdata=%h, required id=%0d addr=%h rdata=%h", g.id, g.addr, g.rdata, e.id, e.addr, e.rdata); end
    end
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_err_sticky: got %b, required 1", timeout_err); end
  endtask
`else
  task automatic test_no_timeout();
    int pulses = 0;
    do_reset();
    sl_stall = 1'b1;
    tick(); m0_valid = 1'b1; m0_addr = 32'h800; m0_wstrb = 4'h0;
    repeat (40) begin
      @(negedge clk);
      if (m0_ready || m1_ready) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL no_timeout_ready: got %0d pulses, required 0", pulses); end
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL no_timeout_grant: got %b, required 01", grant); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL no_timeout_err: got %b, required 0", timeout_err); end
    tick(); m0_valid = 1'b0; sl_stall = 1'b0;
    tick();
  endtask
`endif

  task automatic test_protocol();
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL protocol_ready_rdata: got %0d violations, required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_m1_write();
    test_back_to_back();
    test_reset_mid();
    test_abort();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required summary");
    $fatal(1, "watchdog expired");
  end

endmodule
